// File: rtl/gesture_arm_controller.sv
// Debounces gesture_recognizer results into 4-joint arm poses, slews each joint and drives servo PWM.
// Optional idle safety return to the home pose: define GESTURE_SAFETY_TIMEOUT_EN.
module gesture_arm_controller #(
  parameter int PWM_PERIOD    = 2000000,
  parameter int PULSE_MIN     = 100000,
  parameter int PULSE_SCALE   = 390,
  parameter int STABLE_FRAMES = 3,
  parameter int SLEW_STEP     = 4
`ifdef GESTURE_SAFETY_TIMEOUT_EN
  , parameter int TIMEOUT_FRAMES = 150
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gesture_valid,
  input  logic [3:0]  finger_count,
  output logic [3:0]  servo_pwm,
  output logic        cmd_valid,
  output logic [3:0]  active_gesture,
  output logic [31:0] joint_pos,
  output logic        busy
);

  localparam int             PCW        = $clog2(PWM_PERIOD);
  localparam logic [PCW-1:0] PCNT_LAST  = PCW'(PWM_PERIOD - 1);
  localparam logic [7:0]     STEP       = 8'(SLEW_STEP);
  localparam logic [3:0]     STABLE     = 4'(STABLE_FRAMES);
  localparam logic [3:0]     NO_GESTURE = 4'hF;

  logic           prev_valid;
  logic           evt;
  logic           wrap;
  logic           commit;
  logic           timeout_hit;
  logic [3:0]     cand, cnt, cand_n, cnt_n;
  logic [PCW-1:0] pcnt;
  logic [7:0]     pos   [4];
  logic [7:0]     tgt   [4];
  logic [7:0]     pos_n [4];
  logic [7:0]     tgt_n [4];
  logic [31:0]    pw    [4];

  // Joint order is base, shoulder, elbow, gripper; the gripper homes open at 0.
  function automatic logic [7:0] home_pos(input int j);
    return (j == 3) ? 8'd0 : 8'd128;
  endfunction

  function automatic logic [7:0] slew(input logic [7:0] p, input logic [7:0] t);
    logic [7:0] s;
    s = p;
    if (t > p)      s = (t - p > STEP) ? p + STEP : t;
    else if (p > t) s = (p - t > STEP) ? p - STEP : t;
    return s;
  endfunction

  function automatic logic [31:0] pulse_width(input logic [7:0] p);
    return 32'(PULSE_MIN) + 32'(p) * 32'(PULSE_SCALE);
  endfunction

  assign evt  = gesture_valid && !prev_valid;
  assign wrap = (pcnt == PCNT_LAST);

  // Saturating run-length of identical gestures; commit only on the step that lands on STABLE.
  always_comb begin
    cand_n = cand;
    cnt_n  = cnt;
    commit = 1'b0;
    if (evt) begin
      if (finger_count > 4'd5) begin
        cnt_n = 4'd0;
      end else if (finger_count == cand && cnt != 4'd0) begin
        if (cnt != 4'hF) begin
          cnt_n  = cnt + 4'd1;
          commit = (cnt_n == STABLE);
        end
      end else begin
        cand_n = finger_count;
        cnt_n  = 4'd1;
        commit = (STABLE == 4'd1);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      pos_n[j] = slew(pos[j], tgt[j]);
      tgt_n[j] = timeout_hit ? home_pos(j) : tgt[j];
    end
    if (commit) begin
      case (finger_count)
        4'd0: tgt_n[3] = 8'd255;
        4'd1: tgt_n[0] = 8'd0;
        4'd2: tgt_n[0] = 8'd255;
        4'd3: begin tgt_n[1] = 8'd200; tgt_n[2] = 8'd60;  end
        4'd4: begin tgt_n[1] = 8'd60;  tgt_n[2] = 8'd200; end
        4'd5: tgt_n[3] = 8'd0;
        default: ;
      endcase
    end
  end

`ifdef GESTURE_SAFETY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

  logic [TW-1:0] idle_frames;

  // Idle frame count saturates at TIMEOUT_FRAMES so the return home fires once per quiet spell.
  assign timeout_hit = wrap && !evt && (idle_frames == TW'(TIMEOUT_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (rst)                                          idle_frames <= '0;
    else if (evt)                                     idle_frames <= '0;
    else if (wrap && idle_frames != TW'(TIMEOUT_FRAMES)) idle_frames <= idle_frames + TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Targets update on commit; positions and pulse widths only move on the frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid     <= 1'b1;
      cand           <= 4'd0;
      cnt            <= 4'd0;
      cmd_valid      <= 1'b0;
      active_gesture <= NO_GESTURE;
      pcnt           <= '0;
      servo_pwm      <= 4'b0000;
      for (int j = 0; j < 4; j++) begin
        pos[j] <= home_pos(j);
        tgt[j] <= home_pos(j);
        pw[j]  <= pulse_width(home_pos(j));
      end
    end else begin
      prev_valid <= gesture_valid;
      cand       <= cand_n;
      cnt        <= timeout_hit ? 4'd0 : cnt_n;
      cmd_valid  <= commit;
      if (commit)           active_gesture <= finger_count;
      else if (timeout_hit) active_gesture <= NO_GESTURE;
      pcnt <= wrap ? '0 : pcnt + PCW'(1);
      for (int j = 0; j < 4; j++) begin
        tgt[j]       <= tgt_n[j];
        servo_pwm[j] <= (32'(pcnt) < pw[j]);
        if (wrap) begin
          pos[j] <= pos_n[j];
          pw[j]  <= pulse_width(pos_n[j]);
        end
      end
    end
  end

  assign joint_pos = {pos[3], pos[2], pos[1], pos[0]};
  assign busy      = (pos[0] != tgt[0]) || (pos[1] != tgt[1]) ||
                     (pos[2] != tgt[2]) || (pos[3] != tgt[3]);

endmodule

// File: tb/tb_gesture_arm_controller.sv
// Randomized self-checking bench for gesture_arm_controller against a frame-level behavioural model.
module tb_gesture_arm_controller;

  localparam int P      = 1000;
  localparam int PMIN   = 100;
  localparam int SCALE  = 2;
  localparam int STABLE = 3;
  localparam int STEP   = 4;
`ifdef GESTURE_SAFETY_TIMEOUT_EN
  localparam int TMO    = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        gesture_valid = 1'b0;
  logic [3:0]  finger_count = 4'd0;
  logic [3:0]  servo_pwm;
  logic        cmd_valid;
  logic [3:0]  active_gesture;
  logic [31:0] joint_pos;
  logic        busy;

  always #5 clk = ~clk;

  gesture_arm_controller #(
    .PWM_PERIOD(P), .PULSE_MIN(PMIN), .PULSE_SCALE(SCALE),
    .STABLE_FRAMES(STABLE), .SLEW_STEP(STEP)
`ifdef GESTURE_SAFETY_TIMEOUT_EN
    , .TIMEOUT_FRAMES(TMO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .gesture_valid(gesture_valid), .finger_count(finger_count),
    .servo_pwm(servo_pwm), .cmd_valid(cmd_valid), .active_gesture(active_gesture),
    .joint_pos(joint_pos), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cmd_seen = 0;

  // Reference model state, all plain integers.
  int m_prev = 1, m_run_val = 0, m_run_len = 0, m_active = 15, m_ph = 0, m_idle = 0;
  int m_tgt[4], m_pos[4], m_pw[4], m_pw_done[4];
  bit m_cmd = 0, m_evt = 0, m_wrapped = 0, m_rst = 0, m_done_valid = 0;
  int hi[4];
  int last_width[4];

  function automatic int home(input int j);
    return (j == 3) ? 0 : 128;
  endfunction

  function automatic logic [31:0] exp_joint_pos();
    return 32'((m_pos[3] << 24) | (m_pos[2] << 16) | (m_pos[1] << 8) | m_pos[0]);
  endfunction

  function automatic logic exp_busy();
    for (int j = 0; j < 4; j++) if (m_pos[j] != m_tgt[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_pose(input int fc);
    case (fc)
      0: m_tgt[3] = 255;
      1: m_tgt[0] = 0;
      2: m_tgt[0] = 255;
      3: begin m_tgt[1] = 200; m_tgt[2] = 60;  end
      4: begin m_tgt[1] = 60;  m_tgt[2] = 200; end
      5: m_tgt[3] = 0;
      default: ;
    endcase
  endtask

  // Expected state after the coming rising edge, from the current inputs.
  task automatic model_step();
    bit evt, wrap;
    int d, mv, fc;
    m_cmd = 0; m_evt = 0; m_wrapped = 0; m_rst = rst;
    if (rst) begin
      m_prev = 1; m_run_val = 0; m_run_len = 0; m_active = 15; m_ph = 0; m_idle = 0;
      m_done_valid = 0;
      for (int j = 0; j < 4; j++) begin
        m_tgt[j] = home(j); m_pos[j] = home(j); m_pw[j] = PMIN + home(j) * SCALE;
      end
      return;
    end
    fc   = int'(finger_count);
    evt  = gesture_valid && (m_prev == 0);
    m_prev = int'(gesture_valid);
    wrap = (m_ph == P - 1);
    m_ph = wrap ? 0 : m_ph + 1;
    if (wrap) begin
      m_wrapped = 1; m_done_valid = 1;
      for (int j = 0; j < 4; j++) begin
        d  = m_tgt[j] - m_pos[j];
        mv = (d < 0 ? -d : d);
        if (mv > STEP) mv = STEP;
        m_pos[j] += (d < 0) ? -mv : mv;
        m_pw_done[j] = m_pw[j];
        m_pw[j] = PMIN + m_pos[j] * SCALE;
      end
    end
    if (evt) begin
      m_evt = 1; m_idle = 0;
      if (fc > 5) m_run_len = 0;
      else if (fc == m_run_val && m_run_len != 0) begin
        if (m_run_len < 15) begin
          m_run_len++;
          m_cmd = (m_run_len == STABLE);
        end
      end else begin
        m_run_val = fc; m_run_len = 1;
        m_cmd = (STABLE == 1);
      end
      if (m_cmd) begin m_active = fc; apply_pose(fc); end
    end
`ifdef GESTURE_SAFETY_TIMEOUT_EN
    else if (wrap && m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) begin
        for (int j = 0; j < 4; j++) m_tgt[j] = home(j);
        m_active = 15; m_run_len = 0;
      end
    end
`endif
  endtask

  task automatic observe();
    for (int j = 0; j < 4; j++) hi[j] += int'(servo_pwm[j] === 1'b1);
    if (cmd_valid === 1'b1) cmd_seen++;
    if (m_ph == 0) begin
      if (m_done_valid)
        for (int j = 0; j < 4; j++) begin
          checkOutput($sformatf("pwm_width_j%0d", j), hi[j], m_pw_done[j]);
          last_width[j] = hi[j];
        end
      for (int j = 0; j < 4; j++) hi[j] = 0;
    end
    if (m_rst) begin
      checkOutput("rst_servo_pwm", servo_pwm, 0);
      checkOutput("rst_joint_pos", joint_pos, 32'h0080_8080);
      checkOutput("rst_active", active_gesture, 4'hF);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_cmd_valid", cmd_valid, 0);
    end else if (m_evt || m_wrapped || m_cmd || cmd_valid === 1'b1) begin
      checkOutput("cmd_valid", cmd_valid, m_cmd);
      checkOutput("active_gesture", active_gesture, m_active);
      checkOutput("joint_pos", joint_pos, exp_joint_pos());
      checkOutput("busy", busy, exp_busy());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  task automatic applyStimulus(input int fc, input int hold, input int gap);
    gesture_valid = 1'b1;
    finger_count  = 4'(fc);
    repeat (hold) tick();
    gesture_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic run_wraps(input int n);
    int w = 0;
    int guard = 0;
    while (w < n && guard < n * P + 2) begin
      tick();
      if (m_wrapped) w++;
      guard++;
    end
    if (w < n) checkOutput("wrap_budget", w, n);
  endtask

  task automatic align(input int ph);
    int guard = 0;
    while (m_ph != ph && guard < P + 2) begin
      tick();
      guard++;
    end
    if (m_ph != ph) checkOutput("align_budget", m_ph, ph);
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin hi[j] = 0; last_width[j] = 0; end
    @(negedge clk);

    // Reset with gesture_valid held high through and past reset: no event expected.
    rst = 1'b1; gesture_valid = 1'b1; finger_count = 4'd2;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    gesture_valid = 1'b0;
    tick();
    run_wraps(2);
    checkOutput("reset_width_base", last_width[0], 356);
    checkOutput("reset_width_grip", last_width[3], 100);
    checkOutput("reset_active", active_gesture, 4'hF);

    // Single commit of gesture 2, base ramps toward 255.
    align(10);
    cmd_seen = 0;
    applyStimulus(2, 1, 3);
    applyStimulus(2, 2, 2);
    applyStimulus(2, 1, 3);
    checkOutput("single_cmd_count", cmd_seen, 1);
    checkOutput("single_busy", busy, 1);
    run_wraps(1);
    checkOutput("base_after_1_wrap", joint_pos[7:0], 132);
`ifndef GESTURE_SAFETY_TIMEOUT_EN
    run_wraps(30);
    checkOutput("busy_before_32", busy, 1);
    run_wraps(1);
    checkOutput("base_after_32_wraps", joint_pos[7:0], 255);
    checkOutput("busy_after_32", busy, 0);
`endif

    // Interleaved 2,2,3,3,3 then 7,3,3.
    align(10);
    cmd_seen = 0;
    applyStimulus(2, 1, 2); applyStimulus(2, 1, 2);
    applyStimulus(3, 1, 2); applyStimulus(3, 1, 2); applyStimulus(3, 1, 2);
    checkOutput("interleave_cmd_count", cmd_seen, 1);
    checkOutput("interleave_active", active_gesture, 3);
    run_wraps(1);
    checkOutput("shoulder_step", joint_pos[15:8], 132);
    checkOutput("elbow_step", joint_pos[23:16], 124);
`ifndef GESTURE_SAFETY_TIMEOUT_EN
    checkOutput("base_unchanged", joint_pos[7:0], 255);
`endif
    cmd_seen = 0;
    applyStimulus(7, 1, 2); applyStimulus(3, 1, 2); applyStimulus(3, 1, 2);
    checkOutput("cleared_no_commit", cmd_seen, 0);

    // Held level counts once.
    cmd_seen = 0;
    applyStimulus(5, 100, 3);
    checkOutput("held_no_commit", cmd_seen, 0);

    // Commit coincident with a wrap cycle.
    applyStimulus(0, 1, 2);
    applyStimulus(0, 1, 2);
    align(P - 1);
    gesture_valid = 1'b1; finger_count = 4'd0;
    tick();
    gesture_valid = 1'b0;
    checkOutput("wrap_commit_cmd", cmd_valid, 1);
    checkOutput("wrap_commit_grip_hold", joint_pos[31:24], 0);
    run_wraps(1);
    checkOutput("wrap_commit_grip_step", joint_pos[31:24], 4);

    // Reset in the middle of the gripper ramp.
    run_wraps(3);
    rst = 1'b1;
    tick();
    checkOutput("midramp_joint_pos", joint_pos, 32'h0080_8080);
    checkOutput("midramp_servo", servo_pwm, 0);
    rst = 1'b0;
    tick();

`ifdef GESTURE_SAFETY_TIMEOUT_EN
    // Gesture 1 then silence: targets return home after TMO wraps.
    align(10);
    cmd_seen = 0;
    applyStimulus(1, 1, 2); applyStimulus(1, 1, 2); applyStimulus(1, 1, 2);
    checkOutput("tmo_active_before", active_gesture, 1);
    run_wraps(5);
    checkOutput("tmo_active_after", active_gesture, 4'hF);
    checkOutput("tmo_base_low", joint_pos[7:0], 108);
    checkOutput("tmo_no_extra_cmd", cmd_seen, 1);
    run_wraps(5);
    checkOutput("tmo_base_home", joint_pos[7:0], 128);
    checkOutput("tmo_busy", busy, 0);
`endif

    // Randomized gesture traffic against the model.
    for (int i = 0; i < 40; i++)
      applyStimulus($urandom_range(0, 7), $urandom_range(1, 4), $urandom_range(1, 30));
    run_wraps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
